div_ratio_arb: RTL and testbench

Runtime controller for the even/odd clock-ratio datapath. It shares one programmable divide counter between up to NREQ requesters that want to change the division ratio, arbitrating round-robin. It applies each granted ratio only at a period boundary so the tick stream never contains a runt period. It drives a one-cycle tick enable (oTICK) that downstream logic uses in place of a derived clock, plus status for software and debug.

---
 rtl/div_pkg.sv | 17 +
 rtl/div_ratio_arb_if.sv | 28 ++
 rtl/rr_arb.sv | 32 +++
 rtl/div_ratio_arb.sv | 111 +++++++++++
 tb/tb_div_ratio_arb.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared state encoding, reset divisor and divisor helper for the divide-ratio arbiter.
package div_pkg;

  localparam int DEF_DIV_DFLT = 4;
  // Widest divisor eff_div handles; callers zero-extend narrower values.
  localparam int DIV_W = 64;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
    return (d == '0) ? DIV_W'(1) : d;
  endfunction

endpackage

// File: rtl/div_ratio_arb_if.sv
// Requester/status bundle of the divide-ratio arbiter.
interface div_ratio_arb_if #(
  parameter int WIDE = 32,
  parameter int NREQ = 4
) ();

  localparam int GW = $clog2(NREQ);

  logic [NREQ-1:0]      iREQ;
  logic [NREQ*WIDE-1:0] iDIV;
  logic [NREQ-1:0]      oACK;
  logic [WIDE-1:0]      oDIV;
  logic                 oTICK;
  logic                 oLOAD;
  logic                 oBUSY;
  logic [GW-1:0]        oGNT;

  modport master (
    output iREQ, iDIV,
    input  oACK, oDIV, oTICK, oLOAD, oBUSY, oGNT
  );

  modport slave (
    input  iREQ, iDIV,
    output oACK, oDIV, oTICK, oLOAD, oBUSY, oGNT
  );

endinterface

// File: rtl/rr_arb.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping.
module rr_arb #(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [IW-1:0]   gnt_o,
  output logic            valid_o
);

  localparam logic [IW:0] NR = (IW+1)'(NREQ);

  logic [NREQ-1:0] rot;
  logic [IW-1:0]   off;
  logic [IW:0]     sum;

  // Rotate so bit 0 is the requester the pointer names.
  assign rot = NREQ'({req_i, req_i} >> ptr_i);

  always_comb begin
    off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IW'(i);
    end
  end

  assign sum     = {1'b0, ptr_i} + {1'b0, off};
  assign gnt_o   = (sum >= NR) ? IW'(sum - NR) : sum[IW-1:0];
  assign valid_o = |req_i;

endmodule

// File: rtl/div_ratio_arb.sv
// Programmable tick divider whose ratio is changed by round-robin arbitrated
// requesters; new ratios take effect only at a period boundary.
module div_ratio_arb import div_pkg::*; #(
  parameter int WIDE    = 32,
  parameter int NREQ    = 4,
  parameter int DEF_DIV = DEF_DIV_DFLT
) (
  input  logic            iCLK,
  input  logic            iRST,
  div_ratio_arb_if.slave  bus
);

  localparam int GW = $clog2(NREQ);

  state_e          state_q, state_d;
  logic [WIDE-1:0] cnt_q, cnt_d;
  logic [WIDE-1:0] div_q, div_d;
  logic [WIDE-1:0] pend_q, pend_d;
  logic [GW-1:0]   gnt_q, gnt_d;
  logic [GW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            load_q, load_d;

  logic [WIDE-1:0] eff;
  logic [WIDE-1:0] last;
  logic            tick;
  logic [NREQ-1:0] req_avail;
  logic [GW-1:0]   arb_gnt;
  logic            arb_valid;
  logic [WIDE-1:0] div_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign div_arr[gi] = bus.iDIV[gi*WIDE +: WIDE];
  end

  assign eff  = WIDE'(eff_div(DIV_W'(div_q)));
  assign last = eff - WIDE'(1);
  assign tick = (cnt_q == last);

  // A requester still high in its ACK cycle is not re-granted; it must stay
  // high one more cycle to count as a new request.
  assign req_avail = bus.iREQ & ~ack_q;

  rr_arb #(.NREQ(NREQ)) u_arb (
    .req_i   (req_avail),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .valid_o (arb_valid)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? '0 : cnt_q + WIDE'(1);
    div_d   = div_q;
    pend_d  = pend_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    ack_d   = '0;
    load_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          gnt_d   = arb_gnt;
          pend_d  = div_arr[arb_gnt];
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (tick) begin
          div_d   = pend_q;
          cnt_d   = '0;
          ack_d   = NREQ'(1) << gnt_q;
          load_d  = 1'b1;
          ptr_d   = (gnt_q == GW'(NREQ - 1)) ? '0 : gnt_q + GW'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= WIDE'(DEF_DIV);
      pend_q  <= '0;
      gnt_q   <= '0;
      ptr_q   <= '0;
      ack_q   <= '0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      pend_q  <= pend_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      ack_q   <= ack_d;
      load_q  <= load_d;
    end
  end

  assign bus.oACK  = ack_q;
  assign bus.oDIV  = div_q;
  assign bus.oTICK = tick;
  assign bus.oLOAD = load_q;
  assign bus.oBUSY = (state_q == WAIT);
  assign bus.oGNT  = gnt_q;

endmodule

// File: tb/tb_div_ratio_arb.sv
// Self-checking bench for div_ratio_arb: directed scenarios plus random requesters
// checked against a period-arithmetic reference model.
`timescale 1ns/1ps
module tb_div_ratio_arb;

  localparam int W   = 32;
  localparam int N   = 4;
  localparam int DEF = 4;
  localparam int GW  = $clog2(N);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  div_ratio_arb_if #(.WIDE(W), .NREQ(N)) bus ();

  div_ratio_arb #(.WIDE(W), .NREQ(N), .DEF_DIV(DEF)) dut (
    .iCLK (clk),
    .iRST (rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model: a period train starts at m_start and repeats every eff cycles.
  int unsigned m_div  = DEF;
  int unsigned m_pend = 0;
  int          m_start = 0;
  int          m_gnt = 0;
  int          m_ptr = 0;
  bit          m_busy = 0;
  bit          m_load = 0;
  logic [N-1:0] m_ack = '0;

  function automatic bit exp_tick();
    int e;
    e = (m_div == 0) ? 1 : int'(m_div);
    return ((cyc - m_start) % e) == (e - 1);
  endfunction

  // Advance the model using the inputs currently driven, then move one clock.
  task automatic step();
    logic [N-1:0] nack;
    logic [N-1:0] avail;
    bit           nload;
    int           k;
    nack  = '0;
    nload = 1'b0;
    if (rst) begin
      m_div = DEF; m_start = cyc + 1; m_busy = 0; m_ptr = 0; m_gnt = 0; m_pend = 0;
    end else if (m_busy) begin
      if (exp_tick()) begin
        m_div   = m_pend;
        m_start = cyc + 1;
        nack[m_gnt] = 1'b1;
        nload   = 1'b1;
        m_ptr   = (m_gnt + 1) % N;
        m_busy  = 0;
      end
    end else begin
      avail = bus.iREQ & ~m_ack;
      for (int o = 0; o < N; o++) begin
        k = (m_ptr + o) % N;
        if (avail[k]) begin
          m_busy = 1; m_gnt = k; m_pend = bus.iDIV[k*W +: W];
          break;
        end
      end
    end
    m_ack  = nack;
    m_load = nload;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.iREQ = '0;
    step();
    step();
    rst = 1'b0;
    cyc = 0;
    m_start = 0;
  endtask

  task automatic test_reset();
    bit t;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      t = (c == 3) || (c == 7) || (c == 11);
      checks++;
      if (bus.oTICK !== t) begin
        errors++; $display("FAIL reset_tick c=%0d got %b want %b", c, bus.oTICK, t);
      end
      checks++;
      if ({bus.oACK, bus.oLOAD, bus.oBUSY} !== '0 || bus.oDIV !== 32'd4 || bus.oGNT !== '0) begin
        errors++;
        $display("FAIL reset_state c=%0d got ack=%b load=%b busy=%b div=%0d gnt=%0d want 0/0/0/4/0",
                 c, bus.oACK, bus.oLOAD, bus.oBUSY, bus.oDIV, bus.oGNT);
      end
      step();
    end
  endtask

  task automatic test_single();
    bit t, b, l;
    logic [N-1:0] a;
    int d;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      t = (c < 4) ? (c == 3) : (c == 9 || c == 15);
      b = (c == 2 || c == 3);
      l = (c == 4);
      a = (c == 4) ? 4'b0001 : 4'b0000;
      d = (c >= 4) ? 6 : 4;
      checks++;
      if ({bus.oTICK, bus.oBUSY, bus.oLOAD} !== {t, b, l} || bus.oACK !== a || bus.oDIV !== W'(d)) begin
        errors++;
        $display("FAIL single c=%0d got tick/busy/load=%b%b%b ack=%b div=%0d want %b%b%b ack=%b div=%0d",
                 c, bus.oTICK, bus.oBUSY, bus.oLOAD, bus.oACK, bus.oDIV, t, b, l, a, d);
      end
      if (c == 1) begin bus.iREQ[0] = 1'b1; bus.iDIV[0*W +: W] = 32'd6; end
      if (c == 4) bus.iREQ[0] = 1'b0;
      step();
    end
  endtask

  task automatic test_two_req();
    int eg [15] = '{0, 0, 0, 0, 0, 2, 2, 2, 3, 3, 3, 3, 3, 0, 0};
    bit eb [15] = '{0, 1, 1, 1, 0, 1, 1, 0, 1, 1, 1, 1, 0, 1, 0};
    logic [N-1:0] a;
    do_reset();
    for (int c = 0; c < 15; c++) begin
      a = (c == 4) ? 4'b0001 : (c == 7) ? 4'b0100 : (c == 12) ? 4'b1000 : (c == 14) ? 4'b0001 : 4'b0000;
      checks++;
      if (bus.oGNT !== GW'(eg[c]) || bus.oBUSY !== eb[c] || bus.oACK !== a) begin
        errors++;
        $display("FAIL two_req c=%0d got gnt=%0d busy=%b ack=%b want gnt=%0d busy=%b ack=%b",
                 c, bus.oGNT, bus.oBUSY, bus.oACK, eg[c], eb[c], a);
      end
      case (c)
        0: begin
          bus.iREQ[0] = 1'b1; bus.iDIV[0*W +: W] = 32'd3;
          bus.iREQ[2] = 1'b1; bus.iDIV[2*W +: W] = 32'd5;
        end
        4: bus.iREQ[0] = 1'b0;
        7: begin
          bus.iREQ[2] = 1'b0;
          bus.iREQ[0] = 1'b1; bus.iDIV[0*W +: W] = 32'd2;
          bus.iREQ[3] = 1'b1; bus.iDIV[3*W +: W] = 32'd2;
        end
        12: bus.iREQ[3] = 1'b0;
        14: bus.iREQ[0] = 1'b0;
        default: ;
      endcase
      step();
    end
  endtask

  task automatic test_zero_div();
    bit t, b;
    logic [N-1:0] a;
    int d;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      t = (c < 4) ? (c == 3) : (c < 10) ? 1'b1 : (c == 14 || c == 19);
      b = (c >= 1 && c <= 3) || (c == 9);
      a = (c == 4 || c == 10) ? 4'b0010 : 4'b0000;
      d = (c < 4) ? 4 : (c < 10) ? 0 : 5;
      checks++;
      if ({bus.oTICK, bus.oBUSY} !== {t, b} || bus.oACK !== a || bus.oDIV !== W'(d)) begin
        errors++;
        $display("FAIL zero_div c=%0d got tick/busy=%b%b ack=%b div=%0d want %b%b ack=%b div=%0d",
                 c, bus.oTICK, bus.oBUSY, bus.oACK, bus.oDIV, t, b, a, d);
      end
      if (c == 0) begin bus.iREQ[1] = 1'b1; bus.iDIV[1*W +: W] = 32'd0; end
      if (c == 4 || c == 10) bus.iREQ[1] = 1'b0;
      if (c == 8) begin bus.iREQ[1] = 1'b1; bus.iDIV[1*W +: W] = 32'd5; end
      step();
    end
  endtask

  task automatic test_same_div();
    bit t, b, l;
    logic [N-1:0] a;
    do_reset();
    for (int c = 0; c < 25; c++) begin
      t = (c < 4) ? (c == 3) : (((c - 4) % 7) == 6);
      b = (c >= 1 && c <= 3) || (c >= 6 && c <= 10);
      l = (c == 4 || c == 11);
      a = l ? 4'b0001 : 4'b0000;
      checks++;
      if ({bus.oTICK, bus.oBUSY, bus.oLOAD} !== {t, b, l} || bus.oACK !== a) begin
        errors++;
        $display("FAIL same_div c=%0d got tick/busy/load=%b%b%b ack=%b want %b%b%b ack=%b",
                 c, bus.oTICK, bus.oBUSY, bus.oLOAD, bus.oACK, t, b, l, a);
      end
      if (c == 0 || c == 5) begin bus.iREQ[0] = 1'b1; bus.iDIV[0*W +: W] = 32'd7; end
      if (c == 4 || c == 11) bus.iREQ[0] = 1'b0;
      step();
    end
  endtask

  task automatic test_reset_in_wait();
    bit t;
    do_reset();
    bus.iREQ[2] = 1'b1; bus.iDIV[2*W +: W] = 32'd9;
    step();
    step();
    checks++;
    if (bus.oBUSY !== 1'b1 || bus.oGNT !== 2'd2) begin
      errors++; $display("FAIL rst_wait_pre got busy=%b gnt=%0d want 1/2", bus.oBUSY, bus.oGNT);
    end
    rst = 1'b1;
    bus.iREQ = '0;
    step();
    rst = 1'b0;
    cyc = 0;
    m_start = 0;
    for (int r = 0; r < 9; r++) begin
      t = (r == 3) || (r == 7);
      checks++;
      if (bus.oTICK !== t || {bus.oACK, bus.oLOAD, bus.oBUSY} !== '0 || bus.oDIV !== 32'd4) begin
        errors++;
        $display("FAIL rst_wait r=%0d got tick=%b ack=%b load=%b busy=%b div=%0d want tick=%b 0/0/0/4",
                 r, bus.oTICK, bus.oACK, bus.oLOAD, bus.oBUSY, bus.oDIV, t);
      end
      step();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      checks++;
      if (bus.oTICK !== exp_tick()) begin
        errors++; $display("FAIL rnd_tick cyc=%0d got %b want %b", cyc, bus.oTICK, exp_tick());
      end
      checks++;
      if (bus.oDIV !== W'(m_div)) begin
        errors++; $display("FAIL rnd_div cyc=%0d got %0d want %0d", cyc, bus.oDIV, m_div);
      end
      checks++;
      if (bus.oACK !== m_ack || bus.oLOAD !== m_load) begin
        errors++; $display("FAIL rnd_ack cyc=%0d got ack=%b load=%b want ack=%b load=%b",
                           cyc, bus.oACK, bus.oLOAD, m_ack, m_load);
      end
      checks++;
      if (bus.oBUSY !== m_busy || bus.oGNT !== GW'(m_gnt)) begin
        errors++; $display("FAIL rnd_busy cyc=%0d got busy=%b gnt=%0d want busy=%b gnt=%0d",
                           cyc, bus.oBUSY, bus.oGNT, m_busy, m_gnt);
      end
      rst = ($urandom_range(0, 399) == 0);
      for (int k = 0; k < N; k++) begin
        if (rst || m_ack[k]) begin
          bus.iREQ[k] = 1'b0;
        end else if (!bus.iREQ[k]) begin
          if ($urandom_range(0, 3) == 0) begin
            bus.iREQ[k] = 1'b1;
            bus.iDIV[k*W +: W] = W'($urandom_range(0, 9));
          end
        end else if (m_busy && m_gnt == k && $urandom_range(0, 15) == 0) begin
          bus.iREQ[k] = 1'b0;
        end
      end
      step();
    end
    rst = 1'b0;
  endtask

  initial begin
    bus.iREQ = '0;
    bus.iDIV = '0;
    test_reset();
    test_single();
    test_two_req();
    test_zero_div();
    test_same_div();
    test_reset_in_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
